// File: rtl/mat_tx_streamer.sv
// mat_tx_streamer: streams a ROWS x COLS result matrix byte-wise to a UART transmitter; TX_CHECKSUM_EN appends an XOR checksum byte
module mat_tx_streamer #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    localparam int NB = DATA_W / 8;
    localparam int NE = ROWS * COLS;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam int IW = NE > 1 ? $clog2(NE) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_ACK, WAIT_DONE, NEXT,
`ifdef TX_CHECKSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

    state_t state, nxt;
    logic [IW-1:0] idx;
    logic [BW-1:0] bcnt;
    logic [DATA_W-1:0] shreg;
    logic last_byte, last_elem;
`ifdef TX_CHECKSUM_EN
    logic [7:0] acc;
    logic in_csum;
`endif

    function automatic logic [7:0] pick(input logic [DATA_W-1:0] d, input logic [BW-1:0] k);
        return MSB_FIRST != 0 ? d[DATA_W-1-8*int'(k) -: 8] : d[8*int'(k) +: 8];
    endfunction

    assign last_byte = int'(bcnt) == NB - 1;
    assign last_elem = int'(idx) == NE - 1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? RD_REQ : IDLE;
            RD_REQ:    nxt = RD_WAIT;
            RD_WAIT:   nxt = LOAD;
            LOAD:      nxt = SEND;
            SEND:      nxt = tx_busy ? SEND : WAIT_ACK;
            WAIT_ACK:  nxt = tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: nxt = tx_busy ? WAIT_DONE : NEXT;
`ifdef TX_CHECKSUM_EN
            NEXT:      nxt = (abort || in_csum) ? FIN : !last_byte ? SEND : !last_elem ? RD_REQ : CSUM;
            CSUM:      nxt = SEND;
`else
            NEXT:      nxt = abort ? FIN : !last_byte ? SEND : !last_elem ? RD_REQ : FIN;
`endif
            FIN:       nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en   = state == RD_REQ;
        mem_rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
        tx_start    = state == SEND && !tx_busy;
        busy        = state != IDLE;
        done        = state == FIN;
    end

    // tx_byte is preselected on the way into SEND so it is stable for the whole handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            tx_byte <= '0;
            aborted <= 1'b0;
`ifdef TX_CHECKSUM_EN
            acc     <= '0;
            in_csum <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx     <= '0;
                    aborted <= 1'b0;
`ifdef TX_CHECKSUM_EN
                    acc     <= '0;
                    in_csum <= 1'b0;
`endif
                end
                LOAD: begin
                    shreg   <= mem_rd_data;
                    bcnt    <= '0;
                    tx_byte <= pick(mem_rd_data, '0);
                end
`ifdef TX_CHECKSUM_EN
                SEND: if (!tx_busy && !in_csum) acc <= acc ^ tx_byte;
                CSUM: begin
                    tx_byte <= acc;
                    in_csum <= 1'b1;
                end
`endif
                NEXT: begin
                    if (abort) aborted <= 1'b1;
`ifdef TX_CHECKSUM_EN
                    else if (in_csum) aborted <= 1'b0;
`endif
                    else if (!last_byte) begin
                        bcnt    <= bcnt + BW'(1);
                        tx_byte <= pick(shreg, bcnt + BW'(1));
                    end else if (!last_elem) idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_tx_streamer.sv
// tb_mat_tx_streamer: scoreboard bench over three parameterisations of mat_tx_streamer
module tb_mat_tx_streamer;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] start, abort, mem_rd_en, tx_start, tx_busy, busy, done, aborted, hold;
    logic [7:0] txb [3];
    logic [7:0] addr0, addr1, addr2;
    logic [15:0] rd0;
    logic [31:0] rd1;
    logic [7:0] rd2;
    logic [15:0] mem0 [4];
    logic [31:0] mem1 [2];
    logic [7:0] mem2;
    int tcnt [3];
    int en_cnt0, hits0 [4];
    int nstart [3];
    int passed = 0, total = 0;
    logic [9:0] exp_q [3][$];
    logic [7:0] xacc [3];

    always #5 clk = ~clk;

    mat_tx_streamer u0 (.clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_rd_addr(addr0), .mem_rd_data(rd0),
        .tx_start(tx_start[0]), .tx_byte(txb[0]), .tx_busy(tx_busy[0]),
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0]));

    mat_tx_streamer #(.ROWS(1), .COLS(2), .DATA_W(32), .MSB_FIRST(0)) u1 (.clk(clk), .rst(rst),
        .start(start[1]), .abort(abort[1]), .mem_rd_en(mem_rd_en[1]), .mem_rd_addr(addr1),
        .mem_rd_data(rd1), .tx_start(tx_start[1]), .tx_byte(txb[1]), .tx_busy(tx_busy[1]),
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1]));

    mat_tx_streamer #(.ROWS(1), .COLS(1), .DATA_W(8)) u2 (.clk(clk), .rst(rst),
        .start(start[2]), .abort(abort[2]), .mem_rd_en(mem_rd_en[2]), .mem_rd_addr(addr2),
        .mem_rd_data(rd2), .tx_start(tx_start[2]), .tx_byte(txb[2]), .tx_busy(tx_busy[2]),
        .busy(busy[2]), .done(done[2]), .aborted(aborted[2]));

    // transmitter model: busy for 10 cycles after each tx_start, plus an external hold
    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (tx_start[k]) tcnt[k] <= 10;
            else if (tcnt[k] > 0) tcnt[k] <= tcnt[k] - 1;
    assign tx_busy = {tcnt[2] > 0 || hold[2], tcnt[1] > 0 || hold[1], tcnt[0] > 0 || hold[0]};

    always @(posedge clk) begin
        if (mem_rd_en[0]) begin
            rd0 <= mem0[addr0[1:0]];
            en_cnt0 <= en_cnt0 + 1;
            hits0[addr0[1:0]] <= hits0[addr0[1:0]] + 1;
        end
        if (mem_rd_en[1]) rd1 <= mem1[addr1[0]];
        if (mem_rd_en[2]) rd2 <= mem2;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h required %0h", name, got, want);
    endtask

    always @(negedge clk)
        for (int k = 0; k < 3; k++) begin
            if (tx_start[k]) begin
                nstart[k] <= nstart[k] + 1;
                if (exp_q[k].size() == 0) check($sformatf("unexpected_byte%0d", k), {24'h0, txb[k]}, 32'hFFFF_FFFF);
                else check($sformatf("byte%0d", k), {22'h0, 2'b00, txb[k]}, {22'h0, exp_q[k].pop_front()});
            end
            if (done[k]) begin
                if (exp_q[k].size() == 0) check($sformatf("unexpected_done%0d", k), 32'h200, 32'hFFFF_FFFF);
                else check($sformatf("done%0d", k), {22'h0, 1'b1, aborted[k], 8'h00}, {22'h0, exp_q[k].pop_front()});
            end
        end

    task automatic push_start(input int k);
        xacc[k] = 8'h00;
    endtask

    task automatic push_byte(input int k, input logic [7:0] b);
        exp_q[k].push_back({2'b00, b});
        xacc[k] ^= b;
    endtask

    task automatic push_done(input int k, input logic ab);
`ifdef TX_CHECKSUM_EN
        if (!ab) exp_q[k].push_back({2'b00, xacc[k]});
`endif
        exp_q[k].push_back({1'b1, ab, 8'h00});
    endtask

    task automatic push_bytes8(input int k, input logic [63:0] v);
        for (int i = 7; i >= 0; i--) push_byte(k, v[8*i +: 8]);
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk) start[k] = 1'b1;
        @(negedge clk) start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < 2000 && !done[k]; i++) @(negedge clk);
        check($sformatf("done_seen%0d", k), {31'h0, done[k]}, 1);
        @(negedge clk);
        check($sformatf("queue_empty%0d", k), exp_q[k].size(), 0);
    endtask

    task automatic wait_bytes(input int k, input int n);
        for (int i = 0; i < 2000 && nstart[k] < n; i++) @(negedge clk);
        check($sformatf("byte_count%0d", k), nstart[k], n);
    endtask

    initial begin
        int base, h [4], seen;
        mem0 = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        mem1 = '{32'hDEADBEEF, 32'h01020304};
        mem2 = 8'h5A;
        rst = 1'b1; start = '0; abort = '0; hold = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", {31'h0, busy[k]}, 0);
            check("rst_tx_start", {31'h0, tx_start[k]}, 0);
            check("rst_done", {31'h0, done[k]}, 0);
            check("rst_aborted", {31'h0, aborted[k]}, 0);
            check("rst_rd_en", {31'h0, mem_rd_en[k]}, 0);
            check("rst_tx_byte", {24'h0, txb[k]}, 0);
        end
        check("rst_addr", {24'h0, addr0}, 0);
        rst = 1'b0;

        // full default stream
        base = en_cnt0; h = hits0;
        push_start(0); push_bytes8(0, 64'h1234ABCD0001FF00); push_done(0, 1'b0);
        pulse_start(0);
        wait_done(0);
        check("rd_en_cycles", en_cnt0 - base, 4);
        for (int a = 0; a < 4; a++) check($sformatf("addr%0d_reads", a), hits0[a] - h[a], 1);

        // LSB-first 32-bit elements
        push_start(1); push_bytes8(1, 64'hEFBEADDE04030201); push_done(1, 1'b0);
        pulse_start(1);
        wait_done(1);

        // abort during the third byte, then a clean restart
        nstart[0] = 0;
        push_start(0);
        push_byte(0, 8'h12); push_byte(0, 8'h34); push_byte(0, 8'hAB); push_done(0, 1'b1);
        pulse_start(0);
        wait_bytes(0, 3);
        abort[0] = 1'b1;
        wait_done(0);
        abort[0] = 1'b0;
        check("aborted_held", {31'h0, aborted[0]}, 1);
        check("abort_bytes", nstart[0], 3);
        push_start(0); push_bytes8(0, 64'h1234ABCD0001FF00); push_done(0, 1'b0);
        pulse_start(0);
        repeat (2) @(negedge clk);
        check("aborted_cleared", {31'h0, aborted[0]}, 0);
        wait_done(0);

        // second start mid-stream is dropped; reset during the fifth byte
        nstart[0] = 0;
        push_start(0);
        push_byte(0, 8'h12); push_byte(0, 8'h34); push_byte(0, 8'hAB); push_byte(0, 8'hCD); push_byte(0, 8'h00);
        pulse_start(0);
        wait_bytes(0, 2);
        pulse_start(0);
        wait_bytes(0, 5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("mid_rst_busy", {31'h0, busy[0]}, 0);
        check("mid_rst_tx_start", {31'h0, tx_start[0]}, 0);
        check("mid_rst_done", {31'h0, done[0]}, 0);
        check("mid_rst_addr", {24'h0, addr0}, 0);
        repeat (30) @(negedge clk);
        check("mid_rst_queue", exp_q[0].size(), 0);
        push_start(0); push_bytes8(0, 64'h1234ABCD0001FF00); push_done(0, 1'b0);
        pulse_start(0);
        for (int i = 0; i < 10 && !mem_rd_en[0]; i++) @(negedge clk);
        check("restart_rd_en", {31'h0, mem_rd_en[0]}, 1);
        check("restart_addr", {24'h0, addr0}, 0);
        wait_done(0);

        // 1x1x8 with the transmitter held busy before start
        nstart[2] = 0;
        hold[2] = 1'b1;
        repeat (20) @(negedge clk);
        push_start(2); push_byte(2, 8'h5A); push_done(2, 1'b0);
        pulse_start(2);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start[2]) seen++;
        end
        check("withheld_tx_start", seen, 0);
        check("held_busy", {31'h0, busy[2]}, 1);
        hold[2] = 1'b0;
        wait_done(2);
        check("single_bytes", nstart[2], 1 + (exp_q[2].size()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
